// File: rtl/ysyx_24090003_idu_ctrl_if.sv
// Decode-stage handshake bundle: IFU push side, immediate-generator loop, EXU issue side.
interface ysyx_24090003_idu_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic [31:0]     imm_inst;
    logic [XLEN-1:0] imm_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_imm;
    logic            exu_idle;
    logic            flush;
    logic [31:0]     issue_cnt;

    modport slave (
        input  in_valid, in_pc, in_inst, imm_val, out_ready, exu_idle, flush,
        output in_ready, imm_inst, out_valid, out_pc, out_inst, out_imm, issue_cnt
    );

    modport master (
        output in_valid, in_pc, in_inst, imm_val, out_ready, exu_idle, flush,
        input  in_ready, imm_inst, out_valid, out_pc, out_inst, out_imm, issue_cnt
    );
endinterface

// File: rtl/ysyx_24090003_idu_ctrl.sv
// Decode-stage controller: FIFO-buffers fetched {pc,inst}, issues {pc,inst,imm} to EXU,
// holds SYSTEM/FENCE until EXU is idle, supports flush and counts issued instructions.
module ysyx_24090003_idu_ctrl #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    ysyx_24090003_idu_ctrl_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0]  OPC_FENCE  = 7'b0001111;

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   issue_cnt_q, issue_cnt_d;

    logic            empty;
    logic            full;
    logic            serial;
    logic            push;
    logic            pop;
    logic [31:0]     head_inst;
    logic [XLEN-1:0] head_pc;

    // Handshakes and head selection depend only on registered state plus flush/reset/idle.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        head_inst = 32'd0;
        head_pc   = '0;
        if (!empty) begin
            head_inst = inst_mem_q[rd_ptr_q];
            head_pc   = pc_mem_q[rd_ptr_q];
        end
        serial = (head_inst[6:0] == OPC_SYSTEM) || (head_inst[6:0] == OPC_FENCE);

        bus.in_ready  = !reset && !bus.flush && !full;
        bus.out_valid = !reset && !bus.flush && !empty && (!serial || bus.exu_idle);
        bus.imm_inst  = head_inst;
        bus.out_inst  = head_inst;
        bus.out_pc    = head_pc;
        bus.out_imm   = bus.imm_val;
        bus.issue_cnt = issue_cnt_q;

        push = bus.in_valid && bus.in_ready;
        pop  = bus.out_valid && bus.out_ready;
    end

    // Next-state: flush empties the FIFO but never touches the issue counter.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        issue_cnt_d = issue_cnt_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PW'(1);
                issue_cnt_d = issue_cnt_q + 32'd1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            issue_cnt_q <= 32'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Payload storage is not reset; push is already gated by reset and flush.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= bus.in_pc;
            inst_mem_q[wr_ptr_q] <= bus.in_inst;
        end
    end
endmodule

// File: tb/tb_ysyx_24090003_idu_ctrl.sv
// Directed plus randomized bench for ysyx_24090003_idu_ctrl against a queue-based reference model.
module tb_ysyx_24090003_idu_ctrl;
    logic clock;
    logic reset;

    ysyx_24090003_idu_ctrl_if #(.XLEN(32)) bus ();

    ysyx_24090003_idu_ctrl #(.DEPTH(2), .XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // I-type immediate generator standing in for the external decoder.
    function automatic logic [31:0] immgen(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    assign bus.imm_val = immgen(bus.imm_inst);

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [31:0] m_pc   [$];
    logic [31:0] m_inst [$];
    logic [31:0] m_issued = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model at the edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic ordy, input logic idle, input logic fl, input logic rst);
        logic        is_empty, is_serial, exp_ir, exp_ov, do_push, do_pop;
        logic [31:0] h_inst, h_pc;
        reset         = rst;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = ordy;
        bus.exu_idle  = idle;
        bus.flush     = fl;
        #2;
        is_empty  = (m_inst.size() == 0);
        h_inst    = is_empty ? 32'd0 : m_inst[0];
        h_pc      = is_empty ? 32'd0 : m_pc[0];
        is_serial = (h_inst[6:0] == 7'h73) || (h_inst[6:0] == 7'h0f);
        exp_ir    = !rst && !fl && (m_inst.size() < 2);
        exp_ov    = !rst && !fl && !is_empty && (!is_serial || idle);
        chk("in_ready",  32'(bus.in_ready),  32'(exp_ir));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("out_inst",  bus.out_inst,  h_inst);
        chk("imm_inst",  bus.imm_inst,  h_inst);
        chk("out_pc",    bus.out_pc,    h_pc);
        chk("out_imm",   bus.out_imm,   immgen(h_inst));
        chk("issue_cnt", bus.issue_cnt, m_issued);
        do_push = v && exp_ir;
        do_pop  = exp_ov && ordy;
        @(posedge clock);
        if (rst) begin
            m_pc.delete();
            m_inst.delete();
            m_issued = 32'd0;
        end else if (fl) begin
            m_pc.delete();
            m_inst.delete();
        end else begin
            if (do_pop) begin
                void'(m_pc.pop_front());
                void'(m_inst.pop_front());
                m_issued++;
            end
            if (do_push) begin
                m_pc.push_back(pc);
                m_inst.push_back(inst);
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0;
        bus.out_ready = 1'b0; bus.exu_idle = 1'b1; bus.flush = 1'b0;
        @(posedge clock); #1;
        cycle(0, 0, 0, 0, 1, 0, 1);

        // addi x1,x0,5 issued the cycle after push
        cycle(1, 32'h8000_0000, 32'h0050_0093, 1, 1, 0, 0);
        chk("addi_head", bus.out_inst, 32'h0050_0093);
        chk("addi_imm",  bus.out_imm,  32'd5);
        cycle(0, 0, 0, 1, 1, 0, 0);
        chk("addi_cnt",  bus.issue_cnt, 32'd1);
        cycle(0, 0, 0, 1, 1, 0, 0);

        // back-pressure: two fill, third held until space
        cycle(1, 32'h100, addi(5'd2, 12'd1), 0, 1, 0, 0);
        cycle(1, 32'h104, addi(5'd3, 12'd2), 0, 1, 0, 0);
        cycle(1, 32'h108, addi(5'd4, 12'd3), 0, 1, 0, 0);
        chk("full_rej", 32'(bus.in_ready), 32'd0);
        cycle(1, 32'h108, addi(5'd4, 12'd3), 1, 1, 0, 0);
        cycle(1, 32'h108, addi(5'd4, 12'd3), 1, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 1, 1, 0, 0);
        chk("bp_cnt", bus.issue_cnt, 32'd4);

        // ecall waits for EXU idle
        cycle(1, 32'h200, 32'h0000_0073, 1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);

        // steady push+pop at count 1
        cycle(1, 32'h300, addi(5'd1, 12'd10), 0, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            cycle(1, 32'h304 + 32'(i * 4), addi(5'd1, 12'(11 + i)), 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);
        chk("pp_cnt", bus.issue_cnt, 32'd14);

        // flush with two buffered and input pending
        cycle(1, 32'h400, addi(5'd5, 12'd1), 0, 1, 0, 0);
        cycle(1, 32'h404, addi(5'd5, 12'd2), 0, 1, 0, 0);
        cycle(1, 32'h408, addi(5'd5, 12'd3), 1, 1, 1, 0);
        cycle(1, 32'h408, addi(5'd5, 12'd3), 1, 1, 1, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);

        // reset with entries buffered and issue count 7
        cycle(0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cycle(1, 32'h500 + 32'(i * 4), addi(5'd6, 12'(i)), 0, 1, 0, 0);
            cycle(0, 0, 0, 1, 1, 0, 0);
        end
        cycle(1, 32'h600, addi(5'd7, 12'd1), 0, 1, 0, 0);
        cycle(1, 32'h604, addi(5'd7, 12'd2), 0, 1, 0, 0);
        chk("pre_rst_cnt", bus.issue_cnt, 32'd7);
        cycle(0, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r_inst;
            logic [2:0]  sel;
            r_inst = $urandom;
            sel = 3'($urandom_range(0, 7));
            if (sel == 3'd0) r_inst[6:0] = 7'h73;
            else if (sel == 3'd1) r_inst[6:0] = 7'h0f;
            cycle(1'($urandom), $urandom, r_inst, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 63) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
